// File: rtl/id_scan_param.sv
// Identifier-suffix recogniser: flags when the accepted ASCII stream ends in a
// letter run followed by a digit run whose lengths fall within the parameter limits.
module id_scan_param #(
  parameter int ALPHA_MIN = 1,
  parameter int DIGIT_MIN = 1,
  parameter int DIGIT_MAX = 8,
  parameter int ALLOW_US  = 0,
  parameter int RUN_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             char_valid,
  input  logic [7:0]       char,
  output logic             out,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic [RUN_W-1:0] alpha_run,
  output logic [RUN_W-1:0] digit_run
);

  typedef enum logic [1:0] {IDLE = 2'd0, ALPHA = 2'd1, DIGIT = 2'd2} state_t;

  localparam logic [RUN_W-1:0] A_MIN = RUN_W'(ALPHA_MIN);
  localparam logic [RUN_W-1:0] D_MIN = RUN_W'(DIGIT_MIN);
  localparam logic [RUN_W-1:0] D_MAX = RUN_W'(DIGIT_MAX);

  state_t           state, state_nx;
  logic [RUN_W-1:0] alpha_nx, digit_nx;
  logic             out_nx;

  function automatic logic is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_alp(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) ||
           ((ALLOW_US != 0) && (c == 8'h5F));
  endfunction

  // Saturating increment: a saturated run can never wrap back into the legal window.
  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] r);
    return (r == '1) ? r : r + RUN_W'(1);
  endfunction

  function automatic logic in_match(input state_t s, input logic [RUN_W-1:0] a,
                                    input logic [RUN_W-1:0] d);
    return (s == DIGIT) && (a >= A_MIN) && (d >= D_MIN) && (d <= D_MAX);
  endfunction

  always_comb begin
    state_nx = state;
    alpha_nx = alpha_run;
    digit_nx = digit_run;
    if (char_valid) begin
      if (is_dig(char)) begin
        case (state)
          ALPHA: begin
            state_nx = DIGIT;
            digit_nx = RUN_W'(1);
          end
          DIGIT:   digit_nx = sat_inc(digit_run);
          default: begin
            state_nx = IDLE;
            alpha_nx = '0;
            digit_nx = '0;
          end
        endcase
      end else if (is_alp(char)) begin
        state_nx = ALPHA;
        alpha_nx = (state == ALPHA) ? sat_inc(alpha_run) : RUN_W'(1);
        digit_nx = '0;
      end else begin
        state_nx = IDLE;
        alpha_nx = '0;
        digit_nx = '0;
      end
    end
  end

  assign out    = in_match(state, alpha_run, digit_run);
  assign out_nx = in_match(state_nx, alpha_nx, digit_nx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      alpha_run   <= '0;
      digit_run   <= '0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= char_valid && out_nx && !out;
      if (char_valid) begin
        state     <= state_nx;
        alpha_run <= alpha_nx;
        digit_run <= digit_nx;
        if (out_nx && !out)
          match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_scan_param.sv
// Bench for id_scan_param: four parameter variants share one stream and are compared
// each cycle against a model that rescans the accepted character history.
module tb_id_scan_param;

  logic clk, reset, valid;
  logic [7:0] ch;

  logic        o0, o1, o2, o3, p0, p1, p2, p3;
  logic [15:0] c0, c1, c2;
  logic [1:0]  c3;
  logic [7:0]  a0, a1, a2, d0, d1, d2;
  logic [2:0]  a3, d3;

  id_scan_param u0 (.clk(clk), .reset(reset), .char_valid(valid), .char(ch), .out(o0),
    .match_pulse(p0), .match_count(c0), .alpha_run(a0), .digit_run(d0));
  id_scan_param #(.ALPHA_MIN(2)) u1 (.clk(clk), .reset(reset), .char_valid(valid), .char(ch),
    .out(o1), .match_pulse(p1), .match_count(c1), .alpha_run(a1), .digit_run(d1));
  id_scan_param #(.ALLOW_US(1)) u2 (.clk(clk), .reset(reset), .char_valid(valid), .char(ch),
    .out(o2), .match_pulse(p2), .match_count(c2), .alpha_run(a2), .digit_run(d2));
  id_scan_param #(.DIGIT_MAX(5), .RUN_W(3), .CNT_W(2)) u3 (.clk(clk), .reset(reset),
    .char_valid(valid), .char(ch), .out(o3), .match_pulse(p3), .match_count(c3),
    .alpha_run(a3), .digit_run(d3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  int cfg_amin[4]  = '{1, 2, 1, 1};
  int cfg_dmax[4]  = '{8, 8, 8, 5};
  int cfg_us[4]    = '{0, 0, 1, 0};
  int cfg_rmax[4]  = '{255, 255, 255, 7};
  int cfg_cmod[4]  = '{65536, 65536, 65536, 4};

  logic [7:0] hist[$];
  int m_out[4], m_pulse[4], m_cnt[4], m_ar[4], m_dr[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit t_dig(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  function automatic bit t_alp(input logic [7:0] c, input int us);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || (us != 0 && c == "_");
  endfunction

  // Outputs follow from the trailing digits and the letters just before them.
  function automatic void model_eval(input int i, output int o, output int ar, output int dr);
    int d = 0;
    int a = 0;
    int j = hist.size() - 1;
    while (j >= 0 && t_dig(hist[j])) begin d++; j--; end
    while (j >= 0 && t_alp(hist[j], cfg_us[i])) begin a++; j--; end
    if (d > 0 && a == 0) begin
      ar = 0;
      dr = 0;
    end else begin
      ar = (a > cfg_rmax[i]) ? cfg_rmax[i] : a;
      dr = (d > cfg_rmax[i]) ? cfg_rmax[i] : d;
    end
    o = (d > 0 && a > 0 && ar >= cfg_amin[i] && dr >= 1 && dr <= cfg_dmax[i]) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < 4; i++) begin
        m_out[i] = 0; m_pulse[i] = 0; m_cnt[i] = 0; m_ar[i] = 0; m_dr[i] = 0;
      end
    end else if (valid) begin
      int no, nar, ndr;
      hist.push_back(ch);
      if (hist.size() > 400) void'(hist.pop_front());
      for (int i = 0; i < 4; i++) begin
        model_eval(i, no, nar, ndr);
        m_pulse[i] = (no == 1 && m_out[i] == 0) ? 1 : 0;
        if (m_pulse[i] == 1) m_cnt[i] = (m_cnt[i] + 1) % cfg_cmod[i];
        m_out[i] = no; m_ar[i] = nar; m_dr[i] = ndr;
      end
    end else begin
      for (int i = 0; i < 4; i++) m_pulse[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("out0", 32'(o0), m_out[0]); chk("pulse0", 32'(p0), m_pulse[0]);
      chk("cnt0", 32'(c0), m_cnt[0]); chk("alpha0", 32'(a0), m_ar[0]);
      chk("digit0", 32'(d0), m_dr[0]);
      chk("out1", 32'(o1), m_out[1]); chk("pulse1", 32'(p1), m_pulse[1]);
      chk("cnt1", 32'(c1), m_cnt[1]); chk("alpha1", 32'(a1), m_ar[1]);
      chk("digit1", 32'(d1), m_dr[1]);
      chk("out2", 32'(o2), m_out[2]); chk("pulse2", 32'(p2), m_pulse[2]);
      chk("cnt2", 32'(c2), m_cnt[2]); chk("alpha2", 32'(a2), m_ar[2]);
      chk("digit2", 32'(d2), m_dr[2]);
      chk("out3", 32'(o3), m_out[3]); chk("pulse3", 32'(p3), m_pulse[3]);
      chk("cnt3", 32'(c3), m_cnt[3]); chk("alpha3", 32'(a3), m_ar[3]);
      chk("digit3", 32'(d3), m_dr[3]);
    end
  end

  task automatic put(input logic [7:0] c);
    valid = 1'b1; ch = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input string s);
    for (int k = 0; k < s.len(); k++) put(s[k]);
  endtask

  initial begin
    logic [7:0] c;
    bit last_dig;
    reset = 1'b1; valid = 1'b0; ch = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed = 1;
    chk("lit_reset_out", 32'(o0), 0);
    chk("lit_reset_cnt", 32'(c0), 0);

    put("a");  chk("lit_a_out", 32'(o0), 0);
    put("1");  chk("lit_a1_out", 32'(o0), 1);
    chk("lit_a1_pulse", 32'(p0), 1); chk("lit_a1_cnt", 32'(c0), 1);
    chk("lit_a1_amin2", 32'(o1), 0);
    idle(1);   chk("lit_gap_pulse", 32'(p0), 0);
    send("ab1");
    chk("lit_ab1_amin2_out", 32'(o1), 1); chk("lit_ab1_amin2_cnt", 32'(c1), 1);
    chk("lit_ab1_cnt0", 32'(c0), 2);

    do_reset();
    send("ab12x3"); idle(1);
    chk("lit_ab12x3_out", 32'(o0), 1); chk("lit_ab12x3_cnt", 32'(c0), 2);

    do_reset();
    put("a");
    for (int k = 1; k <= 12; k++) begin
      put("7");
      if (k == 8) chk("lit_8dig_out", 32'(o0), 1);
      if (k == 9) begin
        chk("lit_9dig_out", 32'(o0), 0); chk("lit_9dig_cnt", 32'(c0), 1);
      end
    end
    chk("lit_sat_digit3", 32'(d3), 7); chk("lit_sat_out3", 32'(o3), 0);
    chk("lit_long_digit0", 32'(d0), 12);

    do_reset();
    send("_7");
    chk("lit_us1_out", 32'(o2), 1); chk("lit_us0_out", 32'(o0), 0);
    chk("lit_us0_alpha", 32'(a0), 0);

    do_reset();
    put("a"); idle(3);
    chk("lit_gapa_alpha", 32'(a0), 1); chk("lit_gapa_out", 32'(o0), 0);
    put("1"); idle(3);
    chk("lit_gap1_out", 32'(o0), 1); chk("lit_gap1_cnt", 32'(c0), 1);
    reset = 1'b1; valid = 1'b1; ch = "7";
    @(negedge clk);
    reset = 1'b0;
    chk("lit_rst_out", 32'(o0), 0); chk("lit_rst_cnt", 32'(c0), 0);
    put("5"); chk("lit_rst5_out", 32'(o0), 0);
    idle(1);

    last_dig = 0;
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (last_dig && r < 75) c = 8'("0") + 8'($urandom_range(0, 9));
      else if (r < 40) c = 8'("a") + 8'($urandom_range(0, 25));
      else if (r < 50) c = 8'("A") + 8'($urandom_range(0, 25));
      else if (r < 80) c = 8'("0") + 8'($urandom_range(0, 9));
      else if (r < 88) c = "_";
      else if (r < 94) c = " ";
      else c = "-";
      last_dig = (c >= "0" && c <= "9");
      reset = ($urandom_range(0, 199) == 0);
      valid = ($urandom_range(0, 9) < 8);
      ch = c;
      @(negedge clk);
    end
    reset = 1'b0;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
